// File: rtl/mmio_bus_if.sv
// Shared MMIO bus bundle: two requesting masters, the arbiter's response path,
// and the registered RAM/IO slave side.
interface mmio_bus_if;
  // Handshake: a master holds req and its fields stable until it sees its
  // one-cycle gnt pulse. The matching rvalid pulse follows one cycle after
  // gnt. rdata and dec_err are meaningful only while an rvalid is high.
  logic        m0_req;
  logic        m1_req;
  logic        m0_we;
  logic        m1_we;
  logic [31:0] m0_addr;
  logic [31:0] m1_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m1_wdata;
  logic [2:0]  m0_funct3;
  logic [2:0]  m1_funct3;
  logic        m0_gnt;
  logic        m1_gnt;
  logic        m0_rvalid;
  logic        m1_rvalid;
  logic [31:0] rdata;
  logic        dec_err;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_funct3;
  logic        mem_we;
  logic        io_we;
  logic [31:0] mem_rdata;
  logic [31:0] io_rdata;

  // Arbiter view: takes master requests and slave read data.
  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
           m0_wdata, m1_wdata, m0_funct3, m1_funct3, mem_rdata, io_rdata,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rdata, dec_err,
           s_addr, s_wdata, s_funct3, mem_we, io_we
  );

  // Environment view: masters plus the RAM/IO slaves.
  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
           m0_wdata, m1_wdata, m0_funct3, m1_funct3, mem_rdata, io_rdata,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rdata, dec_err,
           s_addr, s_wdata, s_funct3, mem_we, io_we
  );
endinterface

// File: rtl/mmio_bus_arbiter.sv
// Two-master MMIO arbiter/sequencer with RAM/IO address decode.
// Define MMIO_ARB_RR_EN for round-robin arbitration; fixed m0 priority otherwise.
module mmio_bus_arbiter #(
  parameter logic [31:0] RAM_LIMIT = 32'h0000_1000,
  parameter logic [31:0] IO_BASE   = 32'h0000_1000,
  parameter logic [31:0] IO_LAST   = 32'h0000_100F
) (
  input  logic       clk,
  input  logic       reset,
  mmio_bus_if.slave  bus,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  logic   owner;
  logic   ram_hit_q;
  logic   io_hit_q;

  logic        any_req;
  logic        pick_m1;
  logic        win_we;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic [2:0]  win_funct3;
  logic        win_ram;
  logic        win_io;

`ifdef MMIO_ARB_RR_EN
  // last_owner = 1 after reset so m0 takes the first tie.
  logic last_owner;
  assign pick_m1 = bus.m1_req & (~bus.m0_req | ~last_owner);
`else
  assign pick_m1 = bus.m1_req & ~bus.m0_req;
`endif

  assign any_req    = bus.m0_req | bus.m1_req;
  assign win_we     = pick_m1 ? bus.m1_we     : bus.m0_we;
  assign win_addr   = pick_m1 ? bus.m1_addr   : bus.m0_addr;
  assign win_wdata  = pick_m1 ? bus.m1_wdata  : bus.m0_wdata;
  assign win_funct3 = pick_m1 ? bus.m1_funct3 : bus.m0_funct3;
  assign win_ram    = (win_addr < RAM_LIMIT);
  assign win_io     = (win_addr >= IO_BASE) && (win_addr <= IO_LAST);

  assign state_dbg  = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      owner         <= 1'b0;
      ram_hit_q     <= 1'b0;
      io_hit_q      <= 1'b0;
      bus.m0_gnt    <= 1'b0;
      bus.m1_gnt    <= 1'b0;
      bus.m0_rvalid <= 1'b0;
      bus.m1_rvalid <= 1'b0;
      bus.rdata     <= 32'h0;
      bus.dec_err   <= 1'b0;
      bus.s_addr    <= 32'h0;
      bus.s_wdata   <= 32'h0;
      bus.s_funct3  <= 3'h0;
      bus.mem_we    <= 1'b0;
      bus.io_we     <= 1'b0;
`ifdef MMIO_ARB_RR_EN
      last_owner    <= 1'b1;
`endif
    end else begin
      bus.m0_gnt    <= 1'b0;
      bus.m1_gnt    <= 1'b0;
      bus.m0_rvalid <= 1'b0;
      bus.m1_rvalid <= 1'b0;
      bus.dec_err   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.io_we     <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (any_req) begin
            // Write enables are registered here so they cover exactly the ACCESS cycle.
            state        <= ACCESS;
            owner        <= pick_m1;
            bus.m0_gnt   <= ~pick_m1;
            bus.m1_gnt   <= pick_m1;
            bus.s_addr   <= win_addr;
            bus.s_wdata  <= win_wdata;
            bus.s_funct3 <= win_funct3;
            bus.mem_we   <= win_we & win_ram;
            bus.io_we    <= win_we & win_io;
            ram_hit_q    <= win_ram;
            io_hit_q     <= win_io;
`ifdef MMIO_ARB_RR_EN
            last_owner   <= pick_m1;
`endif
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state         <= RESP;
          bus.rdata     <= ram_hit_q ? bus.mem_rdata :
                           io_hit_q  ? bus.io_rdata  : 32'h0;
          bus.m0_rvalid <= ~owner;
          bus.m1_rvalid <= owner;
          bus.dec_err   <= ~(ram_hit_q | io_hit_q);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed bench for mmio_bus_arbiter with a behavioural RAM and IO slave.
module tb_mmio_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;
  int         n_vec = 0;
  int         n_err = 0;
  logic [31:0] exp_q[$];

  mmio_bus_if bus();

  mmio_bus_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / slave models ----------------
  always #5 clk = ~clk;

  logic [31:0] ram [0:1023];
  logic [31:0] io_reg [0:3];
  logic        mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'hC000_0000 + i;
      ram[4] <= 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) io_reg[i] <= 32'h1000_0000 + i;
      mem_loaded <= 1'b1;
    end else begin
      if (bus.mem_we) ram[bus.s_addr[11:2]] <= bus.s_wdata;
      if (bus.io_we) io_reg[bus.s_addr[3:2]] <= bus.s_wdata;
    end
  end

  assign bus.mem_rdata = ram[bus.s_addr[11:2]];
  assign bus.io_rdata  = io_reg[bus.s_addr[3:2]];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3);
    if (m == 0) begin
      bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = addr;
      bus.m0_wdata = wdata; bus.m0_funct3 = f3;
    end else begin
      bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = addr;
      bus.m1_wdata = wdata; bus.m1_funct3 = f3;
    end
  endtask

  task automatic clr_req(input int m);
    if (m == 0) bus.m0_req = 1'b0;
    else        bus.m1_req = 1'b0;
  endtask

  // One complete access: gnt cycle checks, then response cycle checks.
  task automatic run_access(input int m, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] f3,
                            input logic [31:0] exp_rdata, input logic exp_mem_we,
                            input logic exp_io_we, input logic exp_err);
    logic seen;
    logic my_gnt, other_gnt, my_rv, other_rv;
    seen = 1'b0;
    set_req(m, we, addr, wdata, f3);
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = (m == 0) ? bus.m0_gnt : bus.m1_gnt;
    end
    if (!seen) begin
      check("gnt_timeout", 32'd0, 32'd1);
      clr_req(m);
      return;
    end
    other_gnt = (m == 0) ? bus.m1_gnt : bus.m0_gnt;
    check("other_gnt", {31'd0, other_gnt}, 32'd0);
    check("state_access", {30'd0, state_dbg}, 32'd1);
    check("s_addr", bus.s_addr, addr);
    check("s_wdata", bus.s_wdata, wdata);
    check("s_funct3", {29'd0, bus.s_funct3}, {29'd0, f3});
    check("mem_we", {31'd0, bus.mem_we}, {31'd0, exp_mem_we});
    check("io_we", {31'd0, bus.io_we}, {31'd0, exp_io_we});
    clr_req(m);
    @(negedge clk);
    my_rv    = (m == 0) ? bus.m0_rvalid : bus.m1_rvalid;
    other_rv = (m == 0) ? bus.m1_rvalid : bus.m0_rvalid;
    my_gnt   = (m == 0) ? bus.m0_gnt : bus.m1_gnt;
    check("rvalid", {31'd0, my_rv}, 32'd1);
    check("other_rvalid", {31'd0, other_rv}, 32'd0);
    check("gnt_pulse", {31'd0, my_gnt}, 32'd0);
    check("rdata", bus.rdata, exp_rdata);
    check("dec_err", {31'd0, bus.dec_err}, {31'd0, exp_err});
    check("we_pulse", {30'd0, bus.mem_we, bus.io_we}, 32'd0);
    @(negedge clk);
    my_rv = (m == 0) ? bus.m0_rvalid : bus.m1_rvalid;
    check("rvalid_pulse", {31'd0, my_rv}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int n_gnt;
  int last_cyc;
  logic [31:0] got;

  initial begin
    reset = 1'b0;
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_funct3 = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_funct3 = '0;
    repeat (3) @(negedge clk);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    check("rst_gnt", {30'd0, bus.m0_gnt, bus.m1_gnt}, 32'd0);
    check("rst_rvalid", {29'd0, bus.m0_rvalid, bus.m1_rvalid, bus.dec_err}, 32'd0);
    check("rst_we", {30'd0, bus.mem_we, bus.io_we}, 32'd0);
    check("rst_s_addr", bus.s_addr, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    //         m  we   addr           wdata          f3    exp_rdata      mw   iw   err
    run_access(0, 1'b0, 32'h0000_0010, 32'h0,         3'd2, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    run_access(1, 1'b1, 32'h0000_1004, 32'h5,         3'd2, 32'h1000_0001, 1'b0, 1'b1, 1'b0);
    run_access(0, 1'b0, 32'h0000_1004, 32'h0,         3'd2, 32'h0000_0005, 1'b0, 1'b0, 1'b0);
    run_access(0, 1'b1, 32'h0000_2000, 32'h55,        3'd2, 32'h0,         1'b0, 1'b0, 1'b1);
    run_access(1, 1'b0, 32'h0000_0FFC, 32'h0,         3'd2, 32'hC000_03FF, 1'b0, 1'b0, 1'b0);
    run_access(0, 1'b0, 32'h0000_100F, 32'h0,         3'd0, 32'h1000_0003, 1'b0, 1'b0, 1'b0);
    run_access(1, 1'b0, 32'h0000_1010, 32'h0,         3'd2, 32'h0,         1'b0, 1'b0, 1'b1);
    run_access(0, 1'b1, 32'h0000_0020, 32'h1234_5678, 3'd2, 32'hC000_0008, 1'b1, 1'b0, 1'b0);
    run_access(1, 1'b0, 32'h0000_0020, 32'h0,         3'd5, 32'h1234_5678, 1'b0, 1'b0, 1'b0);

    // Contention: both masters hold req; after 4 grants m0 drops out.
`ifdef MMIO_ARB_RR_EN
    exp_q = '{32'd0, 32'd1, 32'd0, 32'd1, 32'd1};
`else
    exp_q = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
`endif
    set_req(0, 1'b0, 32'h0000_0000, 32'h0, 3'd2);
    set_req(1, 1'b0, 32'h0000_0004, 32'h0, 3'd2);
    n_gnt = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 40 && n_gnt < 5; cyc++) begin
      @(negedge clk);
      if (bus.m0_gnt || bus.m1_gnt) begin
        check("dual_gnt", {31'd0, bus.m0_gnt & bus.m1_gnt}, 32'd0);
        got = {31'd0, bus.m1_gnt};
        check("arb_winner", got, exp_q.pop_front());
        if (n_gnt > 0) check("gnt_spacing", cyc - last_cyc, 32'd2);
        last_cyc = cyc;
        n_gnt++;
        if (n_gnt == 4) clr_req(0);
        if (n_gnt == 5) clr_req(1);
      end
    end
    if (n_gnt < 5) begin
      check("arb_timeout", n_gnt, 32'd5);
      clr_req(0);
      clr_req(1);
    end
    repeat (3) @(negedge clk);

    // Reset during ACCESS of a RAM store.
    set_req(0, 1'b1, 32'h0000_0030, 32'hFFFF_FFFF, 3'd2);
    @(negedge clk);
    check("mid_gnt", {31'd0, bus.m0_gnt}, 32'd1);
    check("mid_mem_we", {31'd0, bus.mem_we}, 32'd1);
    reset = 1'b0;
    #1;
    check("arst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("arst_gnt", {30'd0, bus.m0_gnt, bus.m1_gnt}, 32'd0);
    check("arst_state", {30'd0, state_dbg}, 32'd0);
    check("arst_s_addr", bus.s_addr, 32'd0);
    check("arst_s_wdata", bus.s_wdata, 32'd0);
    clr_req(0);
    repeat (2) @(negedge clk);
    check("arst_rvalid", {29'd0, bus.m0_rvalid, bus.m1_rvalid, bus.dec_err}, 32'd0);
    check("arst_ram_word", ram[12], 32'hC000_000C);
    reset = 1'b1;
    @(negedge clk);
    run_access(1, 1'b0, 32'h0000_0030, 32'h0, 3'd2, 32'hC000_000C, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
